// File: rtl/mitll_jtl_pkg.sv
// Shared constants and the elaboration-time delay computation for the
// MIT-LL style Josephson transmission line model.
package mitll_jtl_pkg;

  localparam int unsigned MAX_DELAY = 16;
  localparam real         BIAS_MIN  = 0.5;
  localparam real         BIAS_MAX  = 2.0;

  // Stage count for a given bias; 0 marks a dead (out-of-range bias) line.
  function automatic int delay_cycles(input real bias, input int base);
    int d;
    if ((bias < BIAS_MIN) || (bias > BIAS_MAX)) begin
      return 0;
    end
    d = int'(real'(base) / bias);
    if (d < 1) begin
      d = 1;
    end
    if (d > int'(MAX_DELAY)) begin
      d = int'(MAX_DELAY);
    end
    return d;
  endfunction

endpackage

// File: rtl/sfq_delay_line.sv
// Fixed-depth pulse shift register; the output flop toggles whenever a
// pulse falls out of the last stage.
module sfq_delay_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic out
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;
  logic             out_d;

  // Shift toward the MSB; the MSB is the stage about to emerge.
  always_comb begin
    stage_d = DEPTH'({stage_q, pulse_in});
    out_d   = out ^ stage_q[DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      out     <= 1'b0;
    end else begin
      stage_q <= stage_d;
      out     <= out_d;
    end
  end

endmodule

// File: rtl/mitll_jtl.sv
// Clocked JTL model: synchronises toggle-encoded SFQ pulses, detects them,
// and replays them after a bias-dependent number of cycles.
module mitll_jtl
  import mitll_jtl_pkg::*;
#(
  parameter real BIAS       = 1.0,
  parameter int  BASE_DELAY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  localparam int unsigned D_CALC    = 32'(delay_cycles(BIAS, BASE_DELAY));
  localparam bit          LINE_DEAD = (D_CALC == 0);
  localparam int unsigned DEPTH     = LINE_DEAD ? 1 : D_CALC;

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic pulse_c;

  // Two-flop synchroniser plus the previous-level flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // A dead line swallows every pulse, so out never leaves 0.
  assign pulse_c = (s2_q ^ prev_q) & ~LINE_DEAD;

  sfq_delay_line #(
    .DEPTH(DEPTH)
  ) u_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_c),
    .out     (out)
  );

endmodule

// File: tb/tb_mitll_jtl.sv
// Directed bench for mitll_jtl: four bias points driven from one shared input.
module tb_mitll_jtl;

  logic clk;
  logic rst_n;
  logic in_s;
  logic out_b10;
  logic out_b20;
  logic out_b08;
  logic out_b04;

  int checks = 0;
  int errors = 0;

  mitll_jtl #(.BIAS(1.0), .BASE_DELAY(4)) u_b10 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .out(out_b10));
  mitll_jtl #(.BIAS(2.0), .BASE_DELAY(4)) u_b20 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .out(out_b20));
  mitll_jtl #(.BIAS(0.8), .BASE_DELAY(4)) u_b08 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .out(out_b08));
  mitll_jtl #(.BIAS(0.4), .BASE_DELAY(4)) u_b04 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .out(out_b04));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    logic q[$];
    logic exp_v;

    rst_n = 1'b0;
    in_s  = 1'b0;
    #2;
    check("reset_b10", out_b10, 1'b0);
    check("reset_b20", out_b20, 1'b0);
    check("reset_b08", out_b08, 1'b0);
    check("reset_b04", out_b04, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      check("idle_b10", out_b10, 1'b0);
    end

    // Single rising toggle: L = 6, 4, 7 for the live lines.
    in_s = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      check("single_b10", out_b10, (n >= 7) ? 1'b1 : 1'b0);
      check("single_b20", out_b20, (n >= 5) ? 1'b1 : 1'b0);
      check("single_b08", out_b08, (n >= 8) ? 1'b1 : 1'b0);
      check("single_b04", out_b04, 1'b0);
    end

    // Back-to-back toggles give a one-cycle blip at the output.
    in_s = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("pair_b10", out_b10, (n == 7) ? 1'b0 : 1'b1);
      check("pair_b20", out_b20, (n == 5) ? 1'b0 : 1'b1);
      check("pair_b08", out_b08, (n == 8) ? 1'b0 : 1'b1);
      check("pair_b04", out_b04, 1'b0);
      if (n == 1) in_s = 1'b1;
    end

    // Ten consecutive toggles: dead line stays quiet, live lines settle to in.
    for (int n = 1; n <= 10; n++) begin
      in_s = ~in_s;
      step();
      check("dead_b04", out_b04, 1'b0);
    end
    for (int n = 1; n <= 12; n++) begin
      step();
      check("dead_tail_b04", out_b04, 1'b0);
    end
    check("burst_b10", out_b10, in_s);
    check("burst_b20", out_b20, in_s);
    check("burst_b08", out_b08, in_s);

    // Mid-flight reset discards the pending pulse.
    in_s = 1'b0;
    repeat (3) step();
    check("prerst_b10", out_b10, 1'b1);
    check("prerst_b20", out_b20, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_b10", out_b10, 1'b0);
    check("rst_async_b20", out_b20, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("postrst_b10", out_b10, 1'b0);
      check("postrst_b20", out_b20, 1'b0);
    end

    // in held high across reset release counts as one pulse.
    rst_n = 1'b0;
    in_s  = 1'b1;
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      check("held_b10", out_b10, (n >= 7) ? 1'b1 : 1'b0);
      check("held_b04", out_b04, 1'b0);
    end

    // Random stream, at most one toggle per cycle: out tracks in 7 samples back.
    for (int k = 0; k < 7; k++) q.push_back(in_s);
    for (int n = 1; n <= 200; n++) begin
      step();
      exp_v = q.pop_front();
      check("random_b10", out_b10, exp_v);
      check("random_b04", out_b04, 1'b0);
      if ($urandom_range(1, 0) == 1) in_s = ~in_s;
      q.push_back(in_s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mitll_jtl.md
MITLL_JTL -- requirements
Module: mitll_jtl

Interface
REQ-001 The parameter BIAS SHALL be real, default 1.0, and give the normalised junction bias; it sets the propagation delay.
REQ-002 The parameter BASE_DELAY SHALL be an integer, default 4, and give the delay-line stages at BIAS = 1.0.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-005 The port in SHALL be an input, 1 bit wide, asynchronous to clk, and carry SFQ pulses in toggle encoding: each level change is one pulse.
REQ-006 The port out SHALL be an output, 1 bit wide, and carry output SFQ pulses in toggle encoding, driven directly from a flop.

Function
REQ-007 in SHALL pass through a 2-flop synchroniser (s1, s2), and a flop prev SHALL hold the previous s2.
REQ-008 A pulse SHALL be detected in any cycle where s2 != prev, giving at most one pulse per cycle.
REQ-009 Two or more toggles of in between consecutive sampling edges SHALL be treated as undefined: an even count is lost and an odd count gives one pulse.
REQ-010 The delay D SHALL be computed at elaboration as round(BASE_DELAY / BIAS), clamped to the range 1..MAX_DELAY (16).
REQ-011 Each detected pulse SHALL enter a D-stage shift register, and out SHALL toggle when a pulse leaves the last stage.
REQ-012 Total latency SHALL be L = 2 + D edges: if edge 0 is the first edge to sample the new in level, out changes immediately after edge L.
REQ-013 Pulses in consecutive cycles SHALL all propagate without loss or merging, with up to D pulses in flight and no back-pressure.
REQ-014 If BIAS < BIAS_MIN (0.5) or BIAS > BIAS_MAX (2.0), the line SHALL be dead: out stays 0 and pulses are discarded.
REQ-015 When no pulses have been lost, out SHALL equal the in level once in has been stable for L cycles.

Reset
REQ-016 While rst_n = 0, s1, s2, prev, every delay stage and out SHALL be 0 immediately, with no dependency on clk.
REQ-017 A reset asserted mid-operation SHALL discard all in-flight pulses, and none SHALL emerge after release.
REQ-018 After release, an in held at 1 SHALL count as one pulse, since it differs from the reset state, and out SHALL reach 1 after L cycles.

Structure
REQ-019 A package mitll_jtl_pkg SHALL hold MAX_DELAY, BIAS_MIN, BIAS_MAX and a constant function delay_cycles(bias, base) implementing REQ-010 and REQ-014.
REQ-020 The shift register and output toggle flop SHALL be one sub-module sfq_delay_line, with a depth parameter and ports clk, rst_n, pulse_in, out.
REQ-021 The top level SHALL contain the synchroniser, the edge detector, the delay computation, and the dead-line gating.

Verification
REQ-022 BIAS = 1.0: reset, then toggle in 0->1 once -> out goes 0->1 exactly 6 edges after the first sampling edge, and stays there.
REQ-023 BIAS = 1.0: toggle in on two consecutive cycles (0->1->0) -> out goes high for exactly 1 cycle, 6 edges after the first toggle.
REQ-024 BIAS = 2.0 (D = 2): single toggle -> out toggles after 4 edges; BIAS = 0.8 (D = 5) -> after 7 edges.
REQ-025 BIAS = 0.4: toggle in 10 times -> out remains 0 throughout.
REQ-026 BIAS = 1.0: toggle in, assert rst_n = 0 three cycles later, then release -> out 0 immediately and no later toggle.
REQ-027 Random toggle stream, at most one toggle per cycle, BIAS = 1.0 -> out equals in delayed by 6 cycles, edge for edge.
